// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// State encodings, word geometry and the fetch-error filler instruction.
package imem_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_READ  = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_RESP  = 3'd3;
  localparam state_t S_WRITE = 3'd4;

  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_port_arbiter.sv
// Fetch/loader arbiter onto a byte-wide, single-port instruction memory.
// Define IMEM_ALIGN_CHECK_EN to reject word accesses with addr[1:0] != 0.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int DATAOUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     f_req_valid,
  output logic                     f_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] f_addr,
  output logic                     f_rsp_valid,
  output logic [DATAOUT_WIDTH-1:0] f_rdata,
  input  logic                     l_req_valid,
  output logic                     l_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] l_addr,
  input  logic [DATAOUT_WIDTH-1:0] l_wdata,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     busy,
  output logic                     err
);

  localparam int BW = DATAOUT_WIDTH - DATA_WIDTH;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] lane;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATAOUT_WIDTH-1:0] wdata_q;
  logic [DATAOUT_WIDTH-1:0] rdata_q;
  logic [BW-1:0] buf_q;
  logic err_q;
  logic chk_en;
  logic idle, l_acc, f_acc, f_mis, l_mis;
  logic mem_act;

`ifdef IMEM_ALIGN_CHECK_EN
  assign chk_en = 1'b1;
`else
  assign chk_en = 1'b0;
`endif

  assign idle  = (state_q == S_IDLE);
  assign l_req_ready = idle;
  assign f_req_ready = idle && !l_req_valid;
  assign l_acc = l_req_valid && idle;
  assign f_acc = f_req_valid && f_req_ready;
  assign f_mis = chk_en && (f_addr[1:0] != 2'b00);
  assign l_mis = chk_en && (l_addr[1:0] != 2'b00);

  assign busy        = !idle;
  assign f_rsp_valid = (state_q == S_RESP);
  assign f_rdata     = rdata_q;
  assign err         = err_q;

  assign mem_act   = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = mem_act ? addr_q + ADDRESS_WIDTH'(cnt_q) : '0;
  assign mem_wdata = mem_we
    ? wdata_q[DATAOUT_WIDTH-1-DATA_WIDTH*int'(cnt_q) -: DATA_WIDTH]
    : '0;

  // byte returned now belongs to the address issued last cycle
  assign lane = cnt_q - 2'd1;

  // next state and byte counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        if (l_acc) begin
          state_d = l_mis ? S_IDLE : S_WRITE;
        end else if (f_acc) begin
          state_d = f_mis ? S_RESP : S_READ;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_WRITE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // state, request latches, byte assembly and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= 1'b0;
      if (l_acc) begin
        addr_q  <= l_addr;
        wdata_q <= l_wdata;
        err_q   <= l_mis;
      end else if (f_acc) begin
        addr_q <= f_addr;
        err_q  <= f_mis;
        if (f_mis) rdata_q <= DATAOUT_WIDTH'(NOP_INSTR);
      end
      if (state_q == S_READ && cnt_q != 2'd0)
        buf_q[BW-1-DATA_WIDTH*int'(lane) -: DATA_WIDTH] <= mem_rdata;
      if (state_q == S_DRAIN)
        rdata_q <= {buf_q, mem_rdata};
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a byte memory model.
// Build with IMEM_ALIGN_CHECK_EN to exercise the alignment-reject path.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_addr;
  logic        f_rsp_valid;
  logic [31:0] f_rdata;
  logic        l_req_valid;
  logic        l_req_ready;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic        tb_pw = 1'b0;
  logic [7:0]  tb_pa = '0;
  logic [7:0]  tb_pd = '0;

  logic [31:0] wr_a [64];
  logic [7:0]  wr_d [64];
  int          wr_n = 0;

  logic [31:0] last_addr [4];

  imem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready),
    .f_addr(f_addr), .f_rsp_valid(f_rsp_valid), .f_rdata(f_rdata),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready),
    .l_addr(l_addr), .l_wdata(l_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // byte memory with registered read
  always @(posedge clk) begin
    if (tb_pw) mem[tb_pa] <= tb_pd;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  // log every byte write
  always @(posedge clk) begin
    if (mem_we && wr_n < 64) begin
      wr_a[wr_n] <= mem_addr;
      wr_d[wr_n] <= mem_wdata;
      wr_n <= wr_n + 1;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_pa = a;
    tb_pd = d;
    tb_pw = 1'b1;
    @(negedge clk);
    tb_pw = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] w,
                          output int lat, output logic e,
                          output logic rdy);
    @(negedge clk);
    f_req_valid = 1'b1;
    f_addr = a;
    #1 rdy = f_req_ready;
    @(posedge clk);
    #1;
    f_req_valid = 1'b0;
    f_addr = 32'h5555_5555;
    lat = -1;
    w = '0;
    e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 4) last_addr[k-1] = mem_addr;
      if (f_rsp_valid) begin
        lat = k;
        w = f_rdata;
        e = err;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    l_req_valid = 1'b1;
    l_addr = a;
    l_wdata = d;
    @(posedge clk);
    #1;
    l_req_valid = 1'b0;
    l_addr = 32'h0;
    l_wdata = 32'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    f_req_valid = 1'b0;
    l_req_valid = 1'b0;
    f_addr = '0;
    l_addr = '0;
    l_wdata = '0;
    poke(8'h00, 8'h12);
    poke(8'h01, 8'h34);
    poke(8'h02, 8'h56);
    poke(8'h03, 8'h78);
    poke(8'h04, 8'h9A);
    poke(8'h05, 8'hBC);
    poke(8'hFE, 8'hA1);
    poke(8'hFF, 8'hB2);
    #1;
    checks++;
    if (busy !== 1'b0 || f_rsp_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b rsp=%b err=%b want 0,0,0",
               busy, f_rsp_valid, err);
    end
    checks++;
    if (f_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 00000000", f_rdata);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_mem we=%b addr=%h wd=%h want 0,0,0",
               mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (f_req_ready !== 1'b1 || l_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready f=%b l=%b want 1,1",
               f_req_ready, l_req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch;
    logic [31:0] w;
    int lat;
    logic e, rdy;
    int n0;
    n0 = wr_n;
    do_fetch(32'h0, w, lat, e, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_ready got %b want 1", rdy);
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL fetch_latency got %0d want 6", lat);
    end
    checks++;
    if (w !== 32'h1234_5678) begin
      errors++;
      $display("FAIL fetch_data got %h want 12345678", w);
    end
    checks++;
    if (last_addr[0] !== 32'h0 || last_addr[3] !== 32'h3) begin
      errors++;
      $display("FAIL fetch_addr got %h..%h want 0..3",
               last_addr[0], last_addr[3]);
    end
    @(negedge clk);
    checks++;
    if (f_rsp_valid !== 1'b0 || f_req_ready !== 1'b1 ||
        f_rdata !== 32'h1234_5678 || wr_n != n0) begin
      errors++;
      $display("FAIL fetch_after rsp=%b rdy=%b data=%h writes=%0d want 0,1,12345678,0",
               f_rsp_valid, f_req_ready, f_rdata, wr_n - n0);
    end
  endtask

  task automatic test_write;
    logic [31:0] w;
    int lat;
    logic e, rdy;
    int n0;
    n0 = wr_n;
    do_write(32'h8, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL write_busy4 got %b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || l_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_idle5 busy=%b lrdy=%b want 0,1",
               busy, l_req_ready);
    end
    checks++;
    if (wr_n - n0 != 4) begin
      errors++;
      $display("FAIL write_count got %0d want 4", wr_n - n0);
    end else begin
      checks++;
      if (wr_a[n0] !== 32'h8 || wr_a[n0+1] !== 32'h9 ||
          wr_a[n0+2] !== 32'hA || wr_a[n0+3] !== 32'hB) begin
        errors++;
        $display("FAIL write_addr got %h %h %h %h want 8 9 a b",
                 wr_a[n0], wr_a[n0+1], wr_a[n0+2], wr_a[n0+3]);
      end
      checks++;
      if ({wr_d[n0], wr_d[n0+1], wr_d[n0+2], wr_d[n0+3]}
          !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL write_bytes got %h%h%h%h want deadbeef",
                 wr_d[n0], wr_d[n0+1], wr_d[n0+2], wr_d[n0+3]);
      end
    end
    do_fetch(32'h8, w, lat, e, rdy);
    checks++;
    if (w !== 32'hDEAD_BEEF || lat != 6) begin
      errors++;
      $display("FAIL write_readback got %h lat %0d want deadbeef lat 6",
               w, lat);
    end
  endtask

  task automatic test_priority;
    int acc, lat;
    @(negedge clk);
    l_req_valid = 1'b1;
    l_addr = 32'h10;
    l_wdata = 32'hCAFE_F00D;
    f_req_valid = 1'b1;
    f_addr = 32'h0;
    #1;
    checks++;
    if (f_req_ready !== 1'b0 || l_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_ready f=%b l=%b want 0,1",
               f_req_ready, l_req_ready);
    end
    @(posedge clk);
    #1 l_req_valid = 1'b0;
    acc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (f_req_ready) begin
        acc = k;
        break;
      end
    end
    checks++;
    if (acc != 5) begin
      errors++;
      $display("FAIL prio_fetch_wait got %0d want 5", acc);
    end
    @(posedge clk);
    #1 f_req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (f_rsp_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 6 || f_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL prio_fetch got %h lat %0d want 12345678 lat 6",
               f_rdata, lat);
    end
    checks++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}
        !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL prio_write got %h%h%h%h want cafef00d",
               mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] w;
    int lat;
    logic e, rdy;
    do_fetch(32'hFFFF_FFFE, w, lat, e, rdy);
    checks++;
    if (last_addr[0] !== 32'hFFFF_FFFE || last_addr[1] !== 32'hFFFF_FFFF ||
        last_addr[2] !== 32'h0 || last_addr[3] !== 32'h1) begin
      errors++;
      $display("FAIL wrap_addr got %h %h %h %h want fffffffe ffffffff 0 1",
               last_addr[0], last_addr[1], last_addr[2], last_addr[3]);
    end
    checks++;
    if (w !== 32'hA1B2_1234) begin
      errors++;
      $display("FAIL wrap_data got %h want a1b21234", w);
    end
  endtask

  task automatic test_reset_mid_write;
    poke(8'h20, 8'h11);
    poke(8'h21, 8'h11);
    poke(8'h22, 8'h11);
    poke(8'h23, 8'h11);
    do_write(32'h20, 32'hA5C3_E7F9);
    repeat (3) @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h22) begin
      errors++;
      $display("FAIL midrst_pre we=%b addr=%h want 1,22", mem_we, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0 ||
        f_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_abort we=%b busy=%b addr=%h rdata=%h want 0,0,0,0",
               mem_we, busy, mem_addr, f_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}
        !== 32'hA5C3_1111) begin
      errors++;
      $display("FAIL midrst_bytes got %h%h%h%h want a5c31111",
               mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]);
    end
  endtask

  task automatic test_unaligned;
    logic [31:0] w;
    int lat;
    logic e, rdy;
`ifdef IMEM_ALIGN_CHECK_EN
    int n0;
    do_fetch(32'h2, w, lat, e, rdy);
    checks++;
    if (lat != 1 || w !== 32'h0000_0013 || e !== 1'b1) begin
      errors++;
      $display("FAIL unaligned_fetch got %h lat %0d err %b want 00000013 lat 1 err 1",
               w, lat, e);
    end
    checks++;
    if (last_addr[0] !== 32'h0) begin
      errors++;
      $display("FAIL unaligned_noaccess addr=%h want 0", last_addr[0]);
    end
    n0 = wr_n;
    do_write(32'h31, 32'h0102_0304);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_write err=%b busy=%b want 1,0", err, busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (wr_n != n0 || err !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_drop writes=%0d err=%b want 0,0",
               wr_n - n0, err);
    end
`else
    do_fetch(32'h2, w, lat, e, rdy);
    checks++;
    if (lat != 6 || w !== 32'h5678_9ABC || e !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_fetch got %h lat %0d err %b want 56789abc lat 6 err 0",
               w, lat, e);
    end
    checks++;
    if (last_addr[0] !== 32'h2 || last_addr[3] !== 32'h5) begin
      errors++;
      $display("FAIL unaligned_addr got %h..%h want 2..5",
               last_addr[0], last_addr[3]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_priority();
    test_wrap();
    test_reset_mid_write();
    test_unaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
